tkg_arbn: RTL and testbench

Clocked, parametrised N-way mutual-exclusion element: the synchronous successor of the two-way `tkg_mutex`. It arbitrates among N four-phase request/grant channels, optionally synchronises asynchronous requests first, and selects the winner by round-robin or fixed priority. It is the tech-mapping target for Teak arbitration components on clocked (FPGA/emulation) flows, where a true analogue mutex cell is unavailable.

---
 rtl/tkg_pkg.sv | 26 ++
 rtl/tkg_sync.sv | 37 +++
 rtl/tkg_arbn.sv | 103 ++++++++++
 tb/tb_tkg_arbn.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tkg_pkg.sv
// rtl/tkg_pkg.sv - shared types, limits and helpers for the clocked N-way arbiter
package tkg_pkg;

    typedef enum logic [0:0] {
        TKG_IDLE  = 1'b0,
        TKG_GRANT = 1'b1
    } tkg_state_e;

    localparam int TKG_N_MIN    = 1;
    localparam int TKG_N_MAX    = 32;
    localparam int TKG_SYNC_MIN = 0;
    localparam int TKG_SYNC_MAX = 3;

    // Index width for n channels; never below one bit so N=1 still has an owner port.
    function automatic int tkg_clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 6; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tkg_sync.sv
// rtl/tkg_sync.sv - W-bit, STAGES-deep bitwise synchroniser; STAGES=0 is a plain wire
module tkg_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         r,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (STAGES == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{clk, r};
            assign q = d;
        end else begin : g_flops
            logic [W-1:0] stage [STAGES];

            always_ff @(posedge clk) begin
                if (r) begin
                    for (int s = 0; s < STAGES; s++) begin
                        stage[s] <= '0;
                    end
                end else begin
                    stage[0] <= d;
                    for (int s = 1; s < STAGES; s++) begin
                        stage[s] <= stage[s-1];
                    end
                end
            end

            assign q = stage[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/tkg_arbn.sv
// rtl/tkg_arbn.sv - clocked N-way mutual-exclusion element with round-robin or fixed priority
module tkg_arbn
    import tkg_pkg::*;
#(
    parameter int N    = 2,
    parameter int SYNC = 2,
    parameter int RR   = 1
) (
    input  logic                      clk,
    input  logic                      r,
    input  logic [N-1:0]              rq,
    output logic [N-1:0]              gt,
    output logic                      busy,
    output logic [tkg_clog2(N)-1:0]   owner
);

    localparam int OW = tkg_clog2(N);
    localparam logic [0:0] S_IDLE  = TKG_IDLE;
    localparam logic [0:0] S_GRANT = TKG_GRANT;

    generate
        if (N < TKG_N_MIN || N > TKG_N_MAX) begin : g_bad_n
            $error("tkg_arbn: N out of range");
        end
        if (SYNC < TKG_SYNC_MIN || SYNC > TKG_SYNC_MAX) begin : g_bad_sync
            $error("tkg_arbn: SYNC out of range");
        end
    endgenerate

    logic [N-1:0]  rs;
    logic [0:0]    state;
    logic [OW-1:0] ptr;
    logic [OW-1:0] win;
    logic          found;
    logic [N-1:0]  win_onehot;

    tkg_sync #(.W(N), .STAGES(SYNC)) u_sync (
        .clk (clk),
        .r   (r),
        .d   (rq),
        .q   (rs)
    );

    // Search upward from ptr with wrap; ptr stays 0 in fixed-priority mode so this
    // degenerates to lowest-index-wins.
    always_comb begin
        int            j;
        logic [OW-1:0] idx;
        win   = '0;
        found = 1'b0;
        j     = 0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            idx = OW'(j);
            if (!found && rs[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state <= S_IDLE;
            gt    <= '0;
            busy  <= 1'b0;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gt    <= win_onehot;
                        owner <= win;
                        busy  <= 1'b1;
                        state <= S_GRANT;
                    end
                end
                default: begin
                    // Release drops gt for at least one cycle before the next grant.
                    if (!rs[owner]) begin
                        gt    <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                        if (RR != 0) begin
                            ptr <= (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tkg_arbn.sv
// tb/tb_tkg_arbn.sv - randomized and directed bench for tkg_arbn against a behavioural model
module tb_tkg_arbn;

    logic       clk;
    logic       r;
    logic [7:0] rq_a;
    logic [7:0] gt_a;
    logic       busy_a;
    logic [2:0] owner_a;
    logic [3:0] rq_b;
    logic [3:0] gt_b;
    logic       busy_b;
    logic [1:0] owner_b;
    logic [2:0] rq_c;
    logic [2:0] gt_c;
    logic       busy_c;
    logic [1:0] owner_c;

    tkg_arbn #(.N(8), .SYNC(2), .RR(1)) dut_a (
        .clk(clk), .r(r), .rq(rq_a), .gt(gt_a), .busy(busy_a), .owner(owner_a)
    );
    tkg_arbn #(.N(4), .SYNC(0), .RR(0)) dut_b (
        .clk(clk), .r(r), .rq(rq_b), .gt(gt_b), .busy(busy_b), .owner(owner_b)
    );
    tkg_arbn #(.N(3), .SYNC(0), .RR(1)) dut_c (
        .clk(clk), .r(r), .rq(rq_c), .gt(gt_c), .busy(busy_c), .owner(owner_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        bit             grant;
        bit [5:0]       owner;
        bit [5:0]       ptr;
        bit [2:0][31:0] pipe;
    } mdl_t;

    // One clock edge of the arbiter as described behaviourally: requests seen after
    // `sync` edges of delay, idle picks the first requester from ptr, grant holds
    // until the grantee's request is seen low.
    function automatic mdl_t mdl_step(mdl_t m, bit [31:0] rq, bit rst, int n, int sync, int rr);
        mdl_t      q;
        bit [31:0] rs;
        int        j;
        q = m;
        if (rst) begin
            q = '0;
            return q;
        end
        if (sync == 0) rs = rq;
        else           rs = m.pipe[sync-1];
        if (!m.grant) begin
            for (int i = 0; i < n; i++) begin
                j = (int'(m.ptr) + i) % n;
                if (!q.grant && rs[j]) begin
                    q.grant = 1'b1;
                    q.owner = j[5:0];
                end
            end
        end else if (!rs[m.owner]) begin
            q.grant = 1'b0;
            if (rr != 0) begin
                j     = (int'(m.owner) + 1) % n;
                q.ptr = j[5:0];
            end
        end
        q.pipe[2] = m.pipe[1];
        q.pipe[1] = m.pipe[0];
        q.pipe[0] = rq;
        return q;
    endfunction

    function automatic logic [31:0] mdl_gt(mdl_t m);
        return m.grant ? (32'd1 << m.owner) : 32'd0;
    endfunction

    mdl_t ma, mb, mc;
    bit   a_random;
    bit   a_seen [8];
    int   a_hold [8];
    int   a_wait [8];
    int   a_max_wait;
    int   b3_grants, b1_grants;
    bit   c_order_on;
    int   c_next;
    logic [2:0] c_prev;

    task automatic tick();
        @(posedge clk);
        ma = mdl_step(ma, {24'b0, rq_a}, r, 8, 2, 1);
        mb = mdl_step(mb, {28'b0, rq_b}, r, 4, 0, 0);
        mc = mdl_step(mc, {29'b0, rq_c}, r, 3, 0, 1);
        #1;
        check("a_gt", gt_a, mdl_gt(ma));
        check("a_busy", busy_a, ma.grant);
        check("a_owner", owner_a, ma.owner);
        check("a_onehot0", $onehot0(gt_a), 1);
        check("b_gt", gt_b, mdl_gt(mb));
        check("b_owner", owner_b, mb.owner);
        check("c_gt", gt_c, mdl_gt(mc));
        check("c_owner", owner_c, mc.owner);
        if (gt_b[3]) b3_grants++;
        if (gt_b[1] && busy_b) b1_grants++;
        if (c_order_on && gt_c != 0 && c_prev == 0) begin
            check("c_rr_order", owner_c, c_next);
            c_next = (c_next + 1) % 3;
        end
        c_prev = gt_c;
        // B: channel 3 always requests; channel 1 is a tight four-phase requester.
        if (rq_b[1] && gt_b[1])        rq_b[1] = 1'b0;
        else if (!rq_b[1] && !gt_b[1]) rq_b[1] = 1'b1;
        // C: every channel drops as soon as granted and re-requests once released.
        for (int i = 0; i < 3; i++) begin
            if (rq_c[i] && gt_c[i])        rq_c[i] = 1'b0;
            else if (!rq_c[i] && !gt_c[i]) rq_c[i] = 1'b1;
        end
        if (a_random) begin
            for (int i = 0; i < 8; i++) begin
                if (rq_a[i]) begin
                    if (gt_a[i]) a_seen[i] = 1'b1;
                    if (a_seen[i]) begin
                        if (a_hold[i] == 0) rq_a[i] = 1'b0;
                        else                a_hold[i]--;
                    end else begin
                        a_wait[i]++;
                        if (a_wait[i] > a_max_wait) a_max_wait = a_wait[i];
                    end
                end else if (!gt_a[i] && $urandom_range(0, 3) == 0) begin
                    rq_a[i]   = 1'b1;
                    a_seen[i] = 1'b0;
                    a_hold[i] = $urandom_range(0, 3);
                    a_wait[i] = 0;
                end
            end
        end
    endtask

    initial begin
        int cnt;
        ma = '0; mb = '0; mc = '0;
        a_random = 1'b0; a_max_wait = 0;
        b3_grants = 0; b1_grants = 0;
        c_order_on = 1'b1; c_next = 0; c_prev = '0;
        r    = 1'b1;
        rq_a = 8'hFF;
        rq_b = 4'b1010;
        rq_c = 3'b111;
        for (int i = 0; i < 3; i++) tick();
        check("rst_gt", gt_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_owner", owner_a, 0);

        r = 1'b0;
        tick();
        check("first_grant_e1", gt_a, 0);
        tick();
        check("first_grant_e2", gt_a, 0);
        tick();
        check("first_grant_e3", gt_a, 8'h01);
        check("first_owner", owner_a, 0);

        for (int i = 0; i < 8; i++) begin
            a_seen[i] = 1'b0;
            a_hold[i] = $urandom_range(0, 3);
            a_wait[i] = 0;
        end
        a_random = 1'b1;
        for (int i = 0; i < 3000; i++) tick();
        a_random = 1'b0;

        rq_a = 8'h00;
        for (int i = 0; i < 12; i++) tick();
        check("a_idle_busy", busy_a, 0);
        rq_a = 8'b0000_0100;
        cnt = 0;
        while (!gt_a[2] && cnt < 10) begin
            tick();
            cnt++;
        end
        check("a_grant2", gt_a, 8'b0000_0100);

        c_order_on = 1'b0;
        r = 1'b1;
        tick();
        check("a_rst_mid_gt", gt_a, 0);
        check("a_rst_mid_busy", busy_a, 0);
        r = 1'b0;
        cnt = 0;
        while (!gt_a[2] && cnt < 10) begin
            tick();
            cnt++;
        end
        check("a_regrant_lat", cnt, 3);
        for (int i = 0; i < 5; i++) tick();

        check("a_no_starve", a_max_wait <= 100, 1);
        check("b_ch3_never", b3_grants, 0);
        check("b_ch1_served", b1_grants > 100, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
